// File: rtl/alu_frame_serializer.sv
// Serial frame generator for the ALU input: operand data packets followed by a cmd packet
// carrying op and a CRC-4 computed while the frame is on the wire.
module alu_frame_serializer #(
  parameter int OPERAND_BYTES = 4,
  parameter int GAP_CYCLES    = 0,
  parameter int DROP_W        = $clog2(OPERAND_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ready,
  input  logic [8*OPERAND_BYTES-1:0] a,
  input  logic [8*OPERAND_BYTES-1:0] b,
  input  logic [2:0]                 op,
  input  logic [DROP_W-1:0]          drop_a,
  input  logic [DROP_W-1:0]          drop_b,
  input  logic [3:0]                 crc_mask,
  output logic                       sin,
  output logic                       done,
  output logic [3:0]                 crc
);

  localparam int NPKT  = 2 * OPERAND_BYTES;
  localparam int DW    = 16 * OPERAND_BYTES;
  localparam int PKT_W = $clog2(NPKT);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(OPERAND_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_GAP,
    S_CMD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]       data_q, data_d;
  logic [2:0]          op_q, op_d;
  logic [3:0]          mask_q, mask_d;
  logic [DROP_W-1:0]   drop_a_q, drop_a_d;
  logic [DROP_W-1:0]   drop_b_q, drop_b_d;
  logic [3:0]          crc_q, crc_d;
  logic                dropped;
  logic                pkt_adv;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic din);
    logic fb;
    fb = din ^ c[3];
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  // Omitted packets still shift their byte through the CRC; only the line is held idle.
  always_comb begin
    if (int'(pkt_cnt_q) < OPERAND_BYTES) begin
      dropped = int'(pkt_cnt_q) < int'(drop_a_q);
    end else begin
      dropped = (int'(pkt_cnt_q) - OPERAND_BYTES) < int'(drop_b_q);
    end
  end

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no branch infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    op_d      = op_q;
    mask_d    = mask_q;
    drop_a_d  = drop_a_q;
    drop_b_d  = drop_b_q;
    crc_d     = crc_q;
    sin       = 1'b1;
    ready     = 1'b0;
    done      = 1'b0;
    pkt_adv   = 1'b0;

    case (state_q)
      S_IDLE: ready = 1'b1;

      S_DATA: begin
        if (bit_cnt_q >= 4'd2 && bit_cnt_q <= 4'd9) begin
          sin    = data_q[DW-1];
          data_d = {data_q[DW-2:0], 1'b0};
          crc_d  = crc_step(crc_q, data_q[DW-1]);
        end else if (bit_cnt_q != 4'd10) begin
          sin = 1'b0;
        end
        if (dropped) sin = 1'b1;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            pkt_adv = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) pkt_adv = 1'b1;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end

      // The trailing {1, op} CRC bits are folded in during the first four cmd bits,
      // so the CRC is final before its first bit goes out at bit 6.
      S_CMD: begin
        case (bit_cnt_q)
          4'd0: begin sin = 1'b0;     crc_d = crc_step(crc_q, 1'b1);     end
          4'd1: begin sin = 1'b1;     crc_d = crc_step(crc_q, op_q[2]);  end
          4'd2: begin sin = 1'b0;     crc_d = crc_step(crc_q, op_q[1]);  end
          4'd3: begin sin = op_q[2];  crc_d = crc_step(crc_q, op_q[0]);  end
          4'd4: sin = op_q[1];
          4'd5: sin = op_q[0];
          4'd6: sin = crc_q[3] ^ mask_q[3];
          4'd7: sin = crc_q[2] ^ mask_q[2];
          4'd8: sin = crc_q[1] ^ mask_q[1];
          4'd9: sin = crc_q[0] ^ mask_q[0];
          default: sin = 1'b1;
        endcase
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (pkt_adv) begin
      if (pkt_cnt_q == PKT_W'(NPKT - 1)) begin
        state_d = S_CMD;
      end else begin
        state_d   = S_DATA;
        pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
      end
    end

    if (start && ready) begin
      state_d   = S_DATA;
      bit_cnt_d = '0;
      pkt_cnt_d = '0;
      crc_d     = '0;
      data_d    = {a, b};
      op_d      = op;
      mask_d    = crc_mask;
      drop_a_d  = (drop_a > DROP_MAX) ? DROP_MAX : drop_a;
      drop_b_d  = (drop_b > DROP_MAX) ? DROP_MAX : drop_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      crc_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      crc_q     <= crc_d;
    end
  end

  // NOTE: the frame payload registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    data_q   <= data_d;
    op_q     <= op_d;
    mask_q   <= mask_d;
    drop_a_q <= drop_a_d;
    drop_b_q <= drop_b_d;
  end

  assign crc = crc_q;

endmodule
